ntt_host_sequencer: RTL and testbench

Host-facing sequencer for the single-butterfly NTT/INTT core wrapper. It accepts one command (NTT or INTT), loads 256 coefficients into the core's input RAM as 128 address pairs, and releases `start`. It then captures the 128 result pairs the core presents while `cal_done` is high and forwards them as a stream. It sits between a bus bridge (HPS/Avalon adapter) and the core, and replaces ad-hoc host toggling of `start`/`we`/addresses.

---
 rtl/ntt_pkg.sv | 20 ++
 rtl/seq_timeout_cnt.sv | 39 +++
 rtl/ntt_host_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_ntt_host_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT core controllers: sequencer state encoding,
// polynomial geometry and transform mode encoding.
package ntt_pkg;

  localparam int N_COEF  = 256;
  localparam int N_PAIRS = N_COEF / 2;

  localparam logic MODE_NTT  = 1'b0;
  localparam logic MODE_INTT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_RUN,
    ST_DRAIN,
    ST_FINISH
  } seq_state_t;

endpackage

// File: rtl/seq_timeout_cnt.sv
// Cycle counter that flags the cycle in which LIMIT enabled cycles have
// elapsed since the last clear; shared by the core controllers.
module seq_timeout_cnt #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [WIDTH-1:0] LAST = LIMIT - 1'b1;

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: count_d gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = en_i && (count_q == LAST);

endmodule

// File: rtl/ntt_host_sequencer.sv
// Host-side sequencer for the NTT/INTT core: loads one polynomial as address
// pairs, releases start, and forwards the core's result pairs as a stream.
module ntt_host_sequencer #(
  parameter int          N_PAIRS = 128,
  parameter logic [15:0] TIMEOUT = 16'd65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_mode,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data_a,
  input  logic [15:0] s_data_b,
  output logic        m_valid,
  output logic [15:0] m_data_a,
  output logic [15:0] m_data_b,
  output logic        m_last,
  output logic        core_start,
  output logic        core_mode,
  output logic        core_we,
  output logic [7:0]  core_addr_a,
  output logic [7:0]  core_addr_b,
  output logic [15:0] core_data_a,
  output logic [15:0] core_data_b,
  input  logic        core_cal_done,
  input  logic        core_done,
  input  logic [15:0] core_data_out1,
  input  logic [15:0] core_data_out2,
  output logic        busy,
  output logic        irq,
  output logic        err
);

  import ntt_pkg::*;

  localparam logic [7:0] LAST_IDX = 8'(N_PAIRS - 1);

  seq_state_t  state_q, state_d;
  logic [7:0]  k_q, k_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        s_ready_q, s_ready_d;
  logic        m_valid_q, m_valid_d;
  logic [15:0] m_data_a_q, m_data_a_d;
  logic [15:0] m_data_b_q, m_data_b_d;
  logic        m_last_q, m_last_d;
  logic        core_start_q, core_start_d;
  logic        core_mode_q, core_mode_d;
  logic        core_we_q, core_we_d;
  logic [7:0]  core_addr_a_q, core_addr_a_d;
  logic [7:0]  core_addr_b_q, core_addr_b_d;
  logic [15:0] core_data_a_q, core_data_a_d;
  logic [15:0] core_data_b_q, core_data_b_d;
  logic        busy_q, busy_d;
  logic        irq_q, irq_d;
  logic        err_q, err_d;

  logic cmd_acc, beat_acc, capture, last_result, timeout_hit;

  // Handshakes use the registered ready, so nothing is accepted in the first cycle after reset.
  assign cmd_acc     = cmd_valid && cmd_ready_q;
  assign beat_acc    = s_valid && s_ready_q;
  assign capture     = core_cal_done && (state_q == ST_RUN || state_q == ST_DRAIN);
  assign last_result = (rcnt_q == LAST_IDX);

  seq_timeout_cnt #(
    .WIDTH (16),
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst),
    .clear_i   (state_q != ST_RUN),
    .en_i      (state_q == ST_RUN),
    .expired_o (timeout_hit)
  );

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    rcnt_d        = rcnt_q;
    err_d         = err_q;
    irq_d         = 1'b0;
    core_mode_d   = core_mode_q;
    core_we_d     = 1'b0;
    core_addr_a_d = core_addr_a_q;
    core_addr_b_d = core_addr_b_q;
    core_data_a_d = core_data_a_q;
    core_data_b_d = core_data_b_q;
    m_valid_d     = 1'b0;
    m_last_d      = 1'b0;
    m_data_a_d    = m_data_a_q;
    m_data_b_d    = m_data_b_q;

    if (capture) begin
      m_valid_d  = 1'b1;
      m_data_a_d = core_data_out1;
      m_data_b_d = core_data_out2;
      m_last_d   = last_result;
      rcnt_d     = rcnt_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_acc) begin
          core_mode_d = cmd_mode;
          err_d       = 1'b0;
          k_d         = '0;
          rcnt_d      = '0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (beat_acc) begin
          core_we_d     = 1'b1;
          core_addr_a_d = {k_q[6:0], 1'b0};
          core_addr_b_d = {k_q[6:0], 1'b1};
          core_data_a_d = s_data_a;
          core_data_b_d = s_data_b;
          k_d           = k_q + 8'd1;
          if (k_q == LAST_IDX) begin
            state_d = ST_KICK;
          end
        end
      end
      // The final write is already registered; KICK only lets it land with start still high.
      ST_KICK: state_d = ST_RUN;
      ST_RUN: begin
        if (core_cal_done) begin
          state_d = last_result ? ST_FINISH : ST_DRAIN;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          irq_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!core_cal_done) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else if (last_result) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        if (core_done) begin
          irq_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered copies of the state being entered.
    cmd_ready_d  = (state_d == ST_IDLE);
    s_ready_d    = (state_d == ST_LOAD);
    core_start_d = (state_d == ST_LOAD) || (state_d == ST_KICK);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      k_q           <= '0;
      rcnt_q        <= '0;
      cmd_ready_q   <= 1'b0;
      s_ready_q     <= 1'b0;
      m_valid_q     <= 1'b0;
      m_data_a_q    <= '0;
      m_data_b_q    <= '0;
      m_last_q      <= 1'b0;
      core_start_q  <= 1'b0;
      core_mode_q   <= MODE_NTT;
      core_we_q     <= 1'b0;
      core_addr_a_q <= '0;
      core_addr_b_q <= '0;
      core_data_a_q <= '0;
      core_data_b_q <= '0;
      busy_q        <= 1'b0;
      irq_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      rcnt_q        <= rcnt_d;
      cmd_ready_q   <= cmd_ready_d;
      s_ready_q     <= s_ready_d;
      m_valid_q     <= m_valid_d;
      m_data_a_q    <= m_data_a_d;
      m_data_b_q    <= m_data_b_d;
      m_last_q      <= m_last_d;
      core_start_q  <= core_start_d;
      core_mode_q   <= core_mode_d;
      core_we_q     <= core_we_d;
      core_addr_a_q <= core_addr_a_d;
      core_addr_b_q <= core_addr_b_d;
      core_data_a_q <= core_data_a_d;
      core_data_b_q <= core_data_b_d;
      busy_q        <= busy_d;
      irq_q         <= irq_d;
      err_q         <= err_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign s_ready     = s_ready_q;
  assign m_valid     = m_valid_q;
  assign m_data_a    = m_data_a_q;
  assign m_data_b    = m_data_b_q;
  assign m_last      = m_last_q;
  assign core_start  = core_start_q;
  assign core_mode   = core_mode_q;
  assign core_we     = core_we_q;
  assign core_addr_a = core_addr_a_q;
  assign core_addr_b = core_addr_b_q;
  assign core_data_a = core_data_a_q;
  assign core_data_b = core_data_b_q;
  assign busy        = busy_q;
  assign irq         = irq_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ntt_host_sequencer.sv
// Directed-random bench for ntt_host_sequencer: drives commands, load streams
// and a scripted core, and compares everything against a queue-based model.
module tb_ntt_host_sequencer;
  import ntt_pkg::*;

  localparam int NP  = 128;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_mode = 1'b0, s_valid = 1'b0;
  logic [15:0] s_data_a = '0, s_data_b = '0;
  logic        core_cal_done = 1'b0, core_done = 1'b0;
  logic [15:0] core_data_out1 = '0, core_data_out2 = '0;

  logic        cmd_ready, s_ready, m_valid, m_last, core_start, core_mode, core_we;
  logic        busy, irq, err;
  logic [15:0] m_data_a, m_data_b, core_data_a, core_data_b;
  logic [7:0]  core_addr_a, core_addr_b;
  logic [89:0] all_outs;

  ntt_host_sequencer #(.N_PAIRS(NP), .TIMEOUT(16'(TMO))) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data_a(s_data_a), .s_data_b(s_data_b),
    .m_valid(m_valid), .m_data_a(m_data_a), .m_data_b(m_data_b), .m_last(m_last),
    .core_start(core_start), .core_mode(core_mode), .core_we(core_we),
    .core_addr_a(core_addr_a), .core_addr_b(core_addr_b),
    .core_data_a(core_data_a), .core_data_b(core_data_b),
    .core_cal_done(core_cal_done), .core_done(core_done),
    .core_data_out1(core_data_out1), .core_data_out2(core_data_out2),
    .busy(busy), .irq(irq), .err(err)
  );

  assign all_outs = {cmd_ready, s_ready, m_valid, m_data_a, m_data_b, m_last, core_start,
                     core_mode, core_we, core_addr_a, core_addr_b, core_data_a, core_data_b,
                     busy, irq, err};

  always #5 clk = ~clk;

  typedef struct { logic [7:0] aa; logic [7:0] ab; logic [15:0] da; logic [15:0] db; logic st; } wr_t;
  typedef struct { logic [15:0] a; logic [15:0] b; logic last; int cyc; } res_t;

  wr_t  wr_q[$];
  res_t res_q[$];
  res_t exp_q[$];
  logic [15:0] pa [NP];
  logic [15:0] pb [NP];

  int   checks = 0, failures = 0;
  int   cyc_now = 0;
  int   irq_cnt, irq_cyc, last_we_cyc, start_fall_cyc, sready_cyc, done_cyc;
  logic irq_err;
  logic prev_start = 1'b0;
  int   iters, gap, dly;
  logic run_mode;

  always @(posedge clk) cyc_now <= cyc_now + 1;

  // Observation of DUT outputs, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (core_we) begin
        wr_q.push_back('{aa: core_addr_a, ab: core_addr_b, da: core_data_a, db: core_data_b, st: core_start});
        last_we_cyc = cyc_now;
      end
      if (m_valid) res_q.push_back('{a: m_data_a, b: m_data_b, last: m_last, cyc: cyc_now});
      if (irq) begin
        irq_cnt++;
        irq_cyc = cyc_now;
        irq_err = err;
      end
      if (prev_start && !core_start) start_fall_cyc = cyc_now;
      if (s_ready) sready_cyc++;
    end
    prev_start = core_start;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_q.delete();
    res_q.delete();
    exp_q.delete();
    irq_cnt = 0; irq_cyc = -1; irq_err = 1'b0;
    last_we_cyc = -1; start_fall_cyc = -1; sready_cyc = 0; done_cyc = -1;
  endtask

  task automatic gen_pairs(input bit ramp);
    for (int k = 0; k < NP; k++) begin
      pa[k] = ramp ? 16'(k) : 16'($urandom);
      pb[k] = ramp ? 16'(k + 256) : 16'($urandom);
    end
  endtask

  task automatic do_cmd(input logic mode);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_mode  = 1'($urandom_range(0, 1));
    check("busy_after_cmd", busy, 1);
    check("cmd_ready_after_cmd", cmd_ready, 0);
    check("core_mode_latched", core_mode, mode);
    check("err_cleared_by_cmd", err, 0);
    check("start_in_load", core_start, 1);
    check("s_ready_in_load", s_ready, 1);
  endtask

  // stall: 0 back-to-back, 1 valid on every other cycle (first idle), 2 random.
  task automatic load_stream(input int stall, input int stop_at, output int n_cyc);
    int k = 0;
    int c = 0;
    while (k < stop_at && c < 1000) begin
      case (stall)
        0:       s_valid = 1'b1;
        1:       s_valid = (c % 2 == 1);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data_a = pa[k];
      s_data_b = pb[k];
      if (s_valid && s_ready) k++;
      @(negedge clk);
      c++;
    end
    s_valid = 1'b0;
    n_cyc = c;
    check("load_beats", k, stop_at);
  endtask

  task automatic run_core(input int n, input int g, input int d, input bit never,
                          input bit poke, input logic mode);
    int w = 0;
    while (core_start !== 1'b0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("start_fall_wait", core_start, 0);
    if (!never) begin
      for (int i = 0; i < g; i++) begin
        if (poke) begin
          cmd_valid = 1'b1;
          cmd_mode  = ~mode;
          s_valid   = 1'b1;
        end
        @(negedge clk);
        if (poke) begin
          check("cmd_ready_while_busy", cmd_ready, 0);
          check("core_mode_unchanged", core_mode, mode);
        end
      end
      cmd_valid = 1'b0;
      s_valid   = 1'b0;
      for (int i = 0; i < n; i++) begin
        core_cal_done  = 1'b1;
        core_data_out1 = 16'($urandom);
        core_data_out2 = 16'($urandom);
        exp_q.push_back('{a: core_data_out1, b: core_data_out2, last: (i == NP - 1), cyc: cyc_now + 1});
        @(negedge clk);
      end
      core_cal_done  = 1'b0;
      core_data_out1 = 16'($urandom);
      core_data_out2 = 16'($urandom);
      repeat (d) @(negedge clk);
      core_done = 1'b1;
      done_cyc  = cyc_now;
      @(negedge clk);
      core_done = 1'b0;
    end
  endtask

  task automatic wait_irq(input logic exp_err);
    int w = 0;
    while (irq_cnt == 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    check("irq_once", irq_cnt, 1);
    check("err_at_irq", irq_err, exp_err);
    check("err_sticky", err, exp_err);
    check("idle_busy", busy, 0);
    check("idle_cmd_ready", cmd_ready, 1);
  endtask

  task automatic check_writes(input int n);
    check("we_count", wr_q.size(), n);
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      check($sformatf("write_%0d", i),
            {wr_q[i].aa, wr_q[i].ab, wr_q[i].da, wr_q[i].db, wr_q[i].st},
            {8'(2 * i), 8'(2 * i + 1), pa[i], pb[i], 1'b1});
    end
  endtask

  task automatic check_results();
    check("result_count", res_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < res_q.size(); i++) begin
      check($sformatf("result_%0d", i),
            {res_q[i].a, res_q[i].b, res_q[i].last, 32'(res_q[i].cyc)},
            {exp_q[i].a, exp_q[i].b, exp_q[i].last, 32'(exp_q[i].cyc)});
    end
  endtask

  initial begin
    #1;
    check("reset_outputs", all_outs, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_reset", cmd_ready, 1);

    // Full NTT, ramp data, back-to-back load, core_done already high in FINISH.
    clear_mon();
    gen_pairs(1'b1);
    do_cmd(MODE_NTT);
    load_stream(0, NP, iters);
    run_core(NP, $urandom_range(0, 20), 0, 1'b0, 1'b0, MODE_NTT);
    wait_irq(1'b0);
    check_writes(NP);
    check("start_fall_after_last_we", start_fall_cyc - last_we_cyc, 1);
    check("load_cycles_full", sready_cyc, NP);
    check_results();
    check("irq_after_done", irq_cyc, done_cyc + 1);

    // Stalled load plus command and stream pokes while running.
    clear_mon();
    gen_pairs(1'b0);
    run_mode = 1'($urandom_range(0, 1));
    do_cmd(run_mode);
    load_stream(1, NP, iters);
    run_core(NP, $urandom_range(3, 20), $urandom_range(1, 5), 1'b0, 1'b1, run_mode);
    wait_irq(1'b0);
    check_writes(NP);
    check("start_fall_after_last_we_stall", start_fall_cyc - last_we_cyc, 1);
    check("load_cycles_stalled", sready_cyc, 2 * NP);
    check_results();
    check("irq_after_done_stall", irq_cyc, done_cyc + 1);

    // Timeout: core never reports results.
    clear_mon();
    gen_pairs(1'b0);
    do_cmd(MODE_NTT);
    load_stream(2, NP, iters);
    run_core(0, 0, 0, 1'b1, 1'b0, MODE_NTT);
    wait_irq(1'b1);
    check("timeout_cycles", irq_cyc - start_fall_cyc, TMO);
    check("timeout_no_results", res_q.size(), 0);
    check("load_cycles_random", sready_cyc, iters);

    // cal_done falls after 60 results.
    clear_mon();
    gen_pairs(1'b0);
    do_cmd(MODE_INTT);
    load_stream(2, NP, iters);
    gap = $urandom_range(0, 10);
    dly = $urandom_range(1, 4);
    run_core(60, gap, dly, 1'b0, 1'b0, MODE_INTT);
    wait_irq(1'b1);
    check_results();
    check("early_irq_after_done", irq_cyc, done_cyc + 1);

    // Reset in the middle of the load.
    clear_mon();
    gen_pairs(1'b0);
    do_cmd(MODE_NTT);
    load_stream(0, 50, iters);
    check("we_before_reset", core_we, 1);
    check("start_before_reset", core_start, 1);
    #2 rst = 1'b0;
    #1;
    check("outputs_async_reset", all_outs, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_midreset", cmd_ready, 1);

    // INTT reload from address 0 after the aborted load.
    clear_mon();
    gen_pairs(1'b0);
    do_cmd(MODE_INTT);
    load_stream(2, NP, iters);
    run_core(NP, $urandom_range(0, 20), $urandom_range(0, 5), 1'b0, 1'b0, MODE_INTT);
    wait_irq(1'b0);
    check_writes(NP);
    check("intt_mode_kept", core_mode, MODE_INTT);
    check_results();
    check("intt_irq_after_done", irq_cyc, done_cyc + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
